// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC controller: FSM state encoding and
// default vector/increment constants.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    IRQ_ENTRY = 2'd2,
    HALT      = 2'd3
  } state_e;

  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam logic [15:0] DEF_IRQ_VEC   = 16'h0004;
  localparam logic [15:0] DEF_INC       = 16'h0001;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: jump, taken branch, interrupt return,
// or sequential increment, in that priority order.
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      OFF_W = 8,
  parameter logic [WIDTH-1:0] INC   = DEF_INC
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             branch_i,
  input  logic             branch_taken_i,
  input  logic [OFF_W-1:0] branch_off_i,
  input  logic             reti_i,
  input  logic [WIDTH-1:0] epc_i,
  output logic [WIDTH-1:0] seq_o,
  output logic             reti_sel_o
);

  logic [WIDTH-1:0] offExt;
  logic [WIDTH-1:0] incPc;

  assign offExt = {{(WIDTH-OFF_W){branch_off_i[OFF_W-1]}}, branch_off_i};
  assign incPc  = pc_i + INC;

  // Branch offsets are relative to the following instruction; all adds wrap.
  always_comb begin
    seq_o      = incPc;
    reti_sel_o = 1'b0;
    if (jump_i) begin
      seq_o = jump_target_i;
    end else if (branch_i && branch_taken_i) begin
      seq_o = incPc + offExt;
    end else if (reti_i) begin
      seq_o      = epc_i;
      reti_sel_o = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle CPU: boot bubble, redirects,
// stalls, single-level interrupt with saved return address, and halt.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      OFF_W     = 8,
  parameter logic [WIDTH-1:0] INC       = DEF_INC,
  parameter logic [WIDTH-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [WIDTH-1:0] IRQ_VEC   = DEF_IRQ_VEC
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             branch_i,
  input  logic             branch_taken_i,
  input  logic [OFF_W-1:0] branch_off_i,
  input  logic             reti_i,
  input  logic             halt_i,
  input  logic             irq_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             fetch_valid_o,
  output logic             irq_ack_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             ie_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             ie_q, ie_d;
  logic             irqPend_q, irqPend_d;
  logic [WIDTH-1:0] seqPc;
  logic             retiSel;

  pc_next_mux #(
    .WIDTH (WIDTH),
    .OFF_W (OFF_W),
    .INC   (INC)
  ) u_next_mux (
    .pc_i           (pc_q),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .branch_i       (branch_i),
    .branch_taken_i (branch_taken_i),
    .branch_off_i   (branch_off_i),
    .reti_i         (reti_i),
    .epc_i          (epc_q),
    .seq_o          (seqPc),
    .reti_sel_o     (retiSel)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VEC;
      epc_q     <= '0;
      ie_q      <= 1'b1;
      irqPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      ie_q      <= ie_d;
      irqPend_q <= irqPend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    ie_d      = ie_q;
    irqPend_d = irqPend_q;
    case (state_q)
      BOOT: begin
        pc_d    = RESET_VEC;
        state_d = RUN;
      end
      RUN: begin
        if (stall_i) begin
          if (irq_i) irqPend_d = 1'b1;
        end else if ((irq_i || irqPend_q) && ie_q && !reti_i) begin
          // Current instruction retires; its own redirect becomes the return address.
          epc_d     = seqPc;
          pc_d      = IRQ_VEC;
          ie_d      = 1'b0;
          irqPend_d = 1'b0;
          state_d   = IRQ_ENTRY;
        end else begin
          pc_d = seqPc;
          if (retiSel) ie_d = 1'b1;
          // An irq colliding with reti is deferred to the next RUN cycle.
          if (reti_i && irq_i) irqPend_d = 1'b1;
          if (halt_i) state_d = HALT;
        end
      end
      IRQ_ENTRY: begin
        state_d = RUN;
      end
      HALT: begin
        if (irq_i && ie_q) begin
          epc_d     = pc_q;
          pc_d      = IRQ_VEC;
          ie_d      = 1'b0;
          irqPend_d = 1'b0;
          state_d   = IRQ_ENTRY;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = (state_q == RUN);
  assign irq_ack_o     = (state_q == IRQ_ENTRY);
  assign epc_o         = epc_q;
  assign ie_o          = ie_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer with a queue-based scoreboard:
// the driver pushes expected post-edge state, a monitor pops and compares.
module tb_pc_sequencer;

  typedef struct packed {
    logic [15:0] step;
    logic [15:0] pc;
    logic        fv;
    logic        ack;
    logic [15:0] epc;
    logic        ie;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jumpTarget = '0;
  logic        branch = 1'b0;
  logic        branchTaken = 1'b0;
  logic [7:0]  branchOff = '0;
  logic        reti = 1'b0;
  logic        halt = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] pc;
  logic        fetchValid;
  logic        irqAck;
  logic [15:0] epc;
  logic        ie;

  exp_t        expQ[$];
  exp_t        monExp;
  int          checks = 0;
  int          failures = 0;
  int          stepNo = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .stall_i        (stall),
    .jump_i         (jump),
    .jump_target_i  (jumpTarget),
    .branch_i       (branch),
    .branch_taken_i (branchTaken),
    .branch_off_i   (branchOff),
    .reti_i         (reti),
    .halt_i         (halt),
    .irq_i          (irq),
    .pc_o           (pc),
    .fetch_valid_o  (fetchValid),
    .irq_ack_o      (irqAck),
    .epc_o          (epc),
    .ie_o           (ie)
  );

  task automatic checkOutput(input string name, input logic [15:0] step,
                             input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s step=%0d actual=0x%04h required=0x%04h", name, step, act, req);
    end
  endtask

  task automatic pushExp(input logic [15:0] ePc, input logic eFv, input logic eAck,
                         input logic [15:0] eEpc, input logic eIe);
    stepNo++;
    expQ.push_back('{step: 16'(stepNo), pc: ePc, fv: eFv, ack: eAck, epc: eEpc, ie: eIe});
  endtask

  // One clock edge with the currently driven inputs; controls are pulses.
  task automatic applyStimulus(input logic [15:0] ePc, input logic eFv, input logic eAck,
                               input logic [15:0] eEpc, input logic eIe);
    @(posedge clk);
    #1;
    pushExp(ePc, eFv, eAck, eEpc, eIe);
    @(negedge clk);
    stall       = 1'b0;
    jump        = 1'b0;
    jumpTarget  = '0;
    branch      = 1'b0;
    branchTaken = 1'b0;
    branchOff   = '0;
    reti        = 1'b0;
    halt        = 1'b0;
    irq         = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        monExp = expQ.pop_front();
        checkOutput("pc", monExp.step, pc, monExp.pc);
        checkOutput("fetch_valid", monExp.step, {15'd0, fetchValid}, {15'd0, monExp.fv});
        checkOutput("irq_ack", monExp.step, {15'd0, irqAck}, {15'd0, monExp.ack});
        checkOutput("epc", monExp.step, epc, monExp.epc);
        checkOutput("ie", monExp.step, {15'd0, ie}, {15'd0, monExp.ie});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #1 rstN = 1'b0;
    #1 pushExp(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    rstN = 1'b1;

    // Boot bubble then sequential fetch
    applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(16'h0002, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Absolute jumps
    jump = 1'b1; jumpTarget = 16'h0005;
    applyStimulus(16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1);
    jump = 1'b1; jumpTarget = 16'd100;
    applyStimulus(16'h0064, 1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(16'h0065, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Branch taken backwards wraps below zero; not-taken falls through
    jump = 1'b1; jumpTarget = 16'h0001;
    applyStimulus(16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1);
    branch = 1'b1; branchTaken = 1'b1; branchOff = 8'hFD;
    applyStimulus(16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1);
    jump = 1'b1; jumpTarget = 16'h0001;
    applyStimulus(16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1);
    branch = 1'b1; branchTaken = 1'b0; branchOff = 8'hFD;
    applyStimulus(16'h0002, 1'b1, 1'b0, 16'h0000, 1'b1);
    branch = 1'b1; branchTaken = 1'b1; branchOff = 8'h05;
    applyStimulus(16'h0008, 1'b1, 1'b0, 16'h0000, 1'b1);

    // Stall holds pc, drops jump, remembers irq pulse
    jump = 1'b1; jumpTarget = 16'h0010;
    applyStimulus(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1);
    stall = 1'b1; jump = 1'b1; jumpTarget = 16'h0050; irq = 1'b1;
    applyStimulus(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1);
    stall = 1'b1; jump = 1'b1; jumpTarget = 16'h0050;
    applyStimulus(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1);
    stall = 1'b1; jump = 1'b1; jumpTarget = 16'h0050;
    applyStimulus(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(16'h0004, 1'b0, 1'b1, 16'h0011, 1'b0);
    applyStimulus(16'h0004, 1'b1, 1'b0, 16'h0011, 1'b0);

    // reti beats a simultaneous irq, which is taken on the next cycle
    reti = 1'b1; irq = 1'b1;
    applyStimulus(16'h0011, 1'b1, 1'b0, 16'h0011, 1'b1);
    applyStimulus(16'h0004, 1'b0, 1'b1, 16'h0012, 1'b0);
    applyStimulus(16'h0004, 1'b1, 1'b0, 16'h0012, 1'b0);
    reti = 1'b1;
    applyStimulus(16'h0012, 1'b1, 1'b0, 16'h0012, 1'b1);

    // Halt, hold while ignoring jumps, wake on irq
    jump = 1'b1; jumpTarget = 16'h0030;
    applyStimulus(16'h0030, 1'b1, 1'b0, 16'h0012, 1'b1);
    halt = 1'b1;
    applyStimulus(16'h0031, 1'b0, 1'b0, 16'h0012, 1'b1);
    for (int i = 0; i < 10; i++) begin
      jump = 1'b1; jumpTarget = 16'h0077;
      applyStimulus(16'h0031, 1'b0, 1'b0, 16'h0012, 1'b1);
    end
    irq = 1'b1;
    applyStimulus(16'h0004, 1'b0, 1'b1, 16'h0031, 1'b0);

    // Async reset during IRQ_ENTRY
    rstN = 1'b0;
    #1 pushExp(16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drain", 16'(stepNo), 16'(expQ.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
